pe_array: RTL and testbench

PE_ARRAY -- requirements
Module: pe_array

---
 rtl/pe_array_pkg.sv | 22 ++
 rtl/pe_array_cell.sv | 60 ++++++
 rtl/pe_array.sv | 135 +++++++++++++
 tb/tb_pe_array.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_array_pkg
// Description : Shared sizing constants for the weight-stationary PE array
//               and its sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_array_pkg;

    localparam int unsigned C_ARRAY_DIM  = 16;
    localparam int unsigned C_DATA_WIDTH = 8;
    localparam int unsigned C_ACC_WIDTH  = 32;
    localparam int unsigned C_IDX_WIDTH  = $clog2(C_ARRAY_DIM);

    // Index type for addressing a row or column of the weight matrix
    typedef logic [C_IDX_WIDTH-1:0] idx_t;

    // Pipeline depth from input sample to aligned output
    localparam int unsigned C_LATENCY = 2 * C_ARRAY_DIM - 2;

endpackage : pe_array_pkg
`default_nettype wire

// File: rtl/pe_array_cell.sv
`default_nettype none
// ============================================================================
// Module      : pe_cell
// Description : One processing element of the weight-stationary array.
//               Holds a stationary weight, passes its data operand to the
//               right and accumulates a signed MAC into the downward psum.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_we, i_w         - weight write strobe / value
//               i_a               - data operand from the left
//               i_psum            - partial sum from the PE above
//               o_a               - registered data operand to the right
//               o_psum            - registered partial sum to the PE below
// Revision    : 1.0 - initial release
// ============================================================================
module pe_cell
    import pe_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = C_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = C_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [DATA_WIDTH-1:0] i_w,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [ACC_WIDTH-1:0]  i_psum,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [ACC_WIDTH-1:0]  o_psum
);

    logic [DATA_WIDTH-1:0]          r_w;
    logic [DATA_WIDTH-1:0]          r_a;
    logic [ACC_WIDTH-1:0]           r_psum;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0]           w_prod_ext;

    assign w_prod     = $signed(i_a) * $signed(r_w);
    // Width cast of a signed value sign-extends the product to the accumulator
    assign w_prod_ext = ACC_WIDTH'(w_prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w    <= '0;
            r_a    <= '0;
            r_psum <= '0;
        end else begin
            if (i_we) begin
                r_w <= i_w;
            end
            r_a    <= i_a;
            // Plain modular add: wraps, never saturates
            r_psum <= i_psum + w_prod_ext;
        end
    end

    assign o_a    = r_a;
    assign o_psum = r_psum;

endmodule : pe_cell
`default_nettype wire

// File: rtl/pe_array.sv
`default_nettype none
// ============================================================================
// Module      : pe_array
// Description : ARRAY_DIM x ARRAY_DIM weight-stationary systolic MAC array.
//               Computes psum_out[c] = sum_r data_in[r] * W[r][c] with
//               internal input skew and output de-skew so that a whole
//               vector enters in one cycle and a whole result leaves in one
//               cycle, 2*ARRAY_DIM-2 edges later. Fully pipelined.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               weight_we/row/col/in       - single-weight write port
//               data_in                    - input vector, row r at [r*DW +: DW]
//               psum_out                   - output vector, col c at [c*AW +: AW]
// Revision    : 1.0 - initial release
// ============================================================================
module pe_array
    import pe_array_pkg::*;
#(
    parameter int unsigned ARRAY_DIM  = C_ARRAY_DIM,
    parameter int unsigned DATA_WIDTH = C_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = C_ACC_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            weight_we,
    input  logic [$clog2(ARRAY_DIM)-1:0]    weight_row,
    input  logic [$clog2(ARRAY_DIM)-1:0]    weight_col,
    input  logic [DATA_WIDTH-1:0]           weight_in,
    input  logic [ARRAY_DIM*DATA_WIDTH-1:0] data_in,
    output logic [ARRAY_DIM*ACC_WIDTH-1:0]  psum_out
);

    localparam int unsigned IDX_WIDTH = $clog2(ARRAY_DIM);

    // Row operand entering column 0, after the per-row skew delay
    logic [DATA_WIDTH-1:0] w_row_sk  [ARRAY_DIM];
    // Grid wiring: operand into / out of each PE, psum into / out of each PE
    logic [DATA_WIDTH-1:0] w_a_in    [ARRAY_DIM][ARRAY_DIM];
    logic [DATA_WIDTH-1:0] w_a_out   [ARRAY_DIM][ARRAY_DIM];
    logic [ACC_WIDTH-1:0]  w_ps_in   [ARRAY_DIM][ARRAY_DIM];
    logic [ACC_WIDTH-1:0]  w_ps_out  [ARRAY_DIM][ARRAY_DIM];

    // ------------------------------------------------------------------
    // Input skew: row r waits r cycles so it meets the psum wavefront
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ARRAY_DIM; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign w_row_sk[r] = data_in[0 +: DATA_WIDTH];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] r_sk [r];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) begin
                        r_sk[i] <= '0;
                    end
                end else begin
                    r_sk[0] <= data_in[r*DATA_WIDTH +: DATA_WIDTH];
                    for (int i = 1; i < r; i++) begin
                        r_sk[i] <= r_sk[i-1];
                    end
                end
            end

            assign w_row_sk[r] = r_sk[r-1];
        end
    end

    // ------------------------------------------------------------------
    // PE grid
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ARRAY_DIM; r++) begin : g_row
        for (genvar c = 0; c < ARRAY_DIM; c++) begin : g_col
            if (c == 0) begin : g_a_edge
                assign w_a_in[r][c] = w_row_sk[r];
            end else begin : g_a_chain
                assign w_a_in[r][c] = w_a_out[r][c-1];
            end

            if (r == 0) begin : g_ps_edge
                assign w_ps_in[r][c] = '0;
            end else begin : g_ps_chain
                assign w_ps_in[r][c] = w_ps_out[r-1][c];
            end

            pe_cell #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_we   (weight_we
                         && (weight_row == IDX_WIDTH'(r))
                         && (weight_col == IDX_WIDTH'(c))),
                .i_w    (weight_in),
                .i_a    (w_a_in[r][c]),
                .i_psum (w_ps_in[r][c]),
                .o_a    (w_a_out[r][c]),
                .o_psum (w_ps_out[r][c])
            );
        end
    end

    // ------------------------------------------------------------------
    // Output de-skew: column c leaves the grid c cycles after column 0,
    // so it is delayed ARRAY_DIM-1-c more cycles to line all columns up.
    // The rightmost column needs no extra stage; its bottom PE register
    // is already the output register.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < ARRAY_DIM; c++) begin : g_deskew
        localparam int unsigned DEPTH = ARRAY_DIM - 1 - c;

        if (DEPTH == 0) begin : g_direct
            assign psum_out[c*ACC_WIDTH +: ACC_WIDTH] = w_ps_out[ARRAY_DIM-1][c];
        end else begin : g_delay
            logic [ACC_WIDTH-1:0] r_ds [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_ds[i] <= '0;
                    end
                end else begin
                    r_ds[0] <= w_ps_out[ARRAY_DIM-1][c];
                    for (int i = 1; i < DEPTH; i++) begin
                        r_ds[i] <= r_ds[i-1];
                    end
                end
            end

            assign psum_out[c*ACC_WIDTH +: ACC_WIDTH] = r_ds[DEPTH-1];
        end
    end

endmodule : pe_array
`default_nettype wire

// File: tb/tb_pe_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_array
// Description : Self-checking bench for pe_array (16x16, 8-bit, 32-bit acc).
//               Table of weight/data patterns with hand-computed column sums,
//               plus streaming and mid-stream reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_array;
    import pe_array_pkg::*;

    localparam int N   = C_ARRAY_DIM;
    localparam int DW  = C_DATA_WIDTH;
    localparam int AW  = C_ACC_WIDTH;
    localparam int IW  = C_IDX_WIDTH;
    localparam int LAT = 30;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              weight_we;
    logic [IW-1:0]     weight_row;
    logic [IW-1:0]     weight_col;
    logic [DW-1:0]     weight_in;
    logic [N*DW-1:0]   data_in;
    logic [N*AW-1:0]   psum_out;

    int checks = 0;
    int errors = 0;

    // Weight modes: 0 uniform value, 1 identity, 2 only W[5][9]=value
    // Data modes  : 0 uniform value, 1 ramp r+1,  2 only element 5=value
    typedef struct {
        string           name;
        int              wmode;
        int              wval;
        int              dmode;
        int              dval;
        logic [N*AW-1:0] exp;
    } vec_t;

    vec_t tbl [7];

    pe_array u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .weight_we  (weight_we),
        .weight_row (weight_row),
        .weight_col (weight_col),
        .weight_in  (weight_in),
        .data_in    (data_in),
        .psum_out   (psum_out)
    );

    always #5 clk = ~clk;

    function automatic logic [N*AW-1:0] splat(input int v);
        logic [N*AW-1:0] e;
        for (int c = 0; c < N; c++) e[c*AW +: AW] = AW'(v);
        return e;
    endfunction

    function automatic logic [N*DW-1:0] make_data(input int mode, input int val);
        logic [N*DW-1:0] d;
        int v;
        for (int r = 0; r < N; r++) begin
            case (mode)
                0:       v = val;
                1:       v = r + 1;
                default: v = (r == 5) ? val : 0;
            endcase
            d[r*DW +: DW] = DW'(v);
        end
        return d;
    endfunction

    task automatic check(input string name, input logic [N*AW-1:0] act,
                         input logic [N*AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_weights(input int mode, input int val);
        int wv;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (mode)
                    0:       wv = val;
                    1:       wv = (r == c) ? 1 : 0;
                    default: wv = (r == 5 && c == 9) ? val : 0;
                endcase
                weight_we  = 1'b1;
                weight_row = IW'(r);
                weight_col = IW'(c);
                weight_in  = DW'(wv);
                @(posedge clk);
                #1;
            end
        end
        weight_we = 1'b0;
    endtask

    // Present one vector, then check zero one cycle early, the result on
    // the exact latency edge, and zero again one cycle later.
    task automatic run_vector(input string name, input logic [N*DW-1:0] d,
                              input logic [N*AW-1:0] exp);
        data_in = d;
        @(posedge clk);            // sample edge k
        #1;
        data_in = '0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        check({name, "_early"}, psum_out, '0);
        @(posedge clk);            // edge k+30
        #1;
        check(name, psum_out, exp);
        @(posedge clk);
        #1;
        check({name, "_late"}, psum_out, '0);
    endtask

    initial begin
        logic [N*AW-1:0] e_id;
        logic [N*AW-1:0] e_sc;
        logic [N*AW-1:0] first_bad;
        bit              seen_bad;

        for (int c = 0; c < N; c++) e_id[c*AW +: AW] = AW'(c + 1);
        e_sc = '0;
        e_sc[9*AW +: AW] = 32'd21;

        tbl[0] = '{"ones_x1",     0,    1, 0,    1, splat(16)};
        tbl[1] = '{"ones_x2",     0,    1, 0,    2, splat(32)};
        tbl[2] = '{"identity",    1,    0, 1,    0, e_id};
        tbl[3] = '{"neg_extreme", 0, -128, 0, -128, splat(262144)};
        tbl[4] = '{"pos127_neg1", 0,  127, 0,   -1, splat(-2032)};
        tbl[5] = '{"single_cell", 2,    3, 2,    7, e_sc};
        tbl[6] = '{"neg1_ramp",   0,   -1, 1,    0, splat(-136)};

        rst_n      = 1'b0;
        weight_we  = 1'b0;
        weight_row = '0;
        weight_col = '0;
        weight_in  = '0;
        data_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", psum_out, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Weights come out of reset as zero
        run_vector("zero_weights", make_data(0, 5), '0);

        for (int i = 0; i < 7; i++) begin
            load_weights(tbl[i].wmode, tbl[i].wval);
            run_vector(tbl[i].name, make_data(tbl[i].dmode, tbl[i].dval), tbl[i].exp);
        end

        // Back-to-back streaming with all weights 1
        load_weights(0, 1);
        for (int v = 1; v <= 4; v++) begin
            data_in = make_data(0, v);
            @(posedge clk);
            #1;
        end
        data_in = '0;
        repeat (LAT - 4) @(posedge clk);
        #1;
        check("stream_early", psum_out, '0);
        for (int v = 1; v <= 4; v++) begin
            @(posedge clk);
            #1;
            check($sformatf("stream_%0d", v), psum_out, splat(16 * v));
        end
        @(posedge clk);
        #1;
        check("stream_after", psum_out, '0);

        // Reset with vectors in flight
        for (int v = 1; v <= 4; v++) begin
            data_in = make_data(0, v);
            @(posedge clk);
            #1;
        end
        data_in = '0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", psum_out, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen_bad  = 1'b0;
        first_bad = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!seen_bad && psum_out !== '0) begin
                seen_bad  = 1'b1;
                first_bad = psum_out;
            end
        end
        check("rst_flush", first_bad, '0);

        // Weights were cleared by reset, so a nonzero vector still gives zero
        run_vector("rst_weights_cleared", make_data(0, 1), '0);

        load_weights(0, 1);
        run_vector("rst_recover", make_data(0, 1), splat(16));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pe_array
`default_nettype wire
